rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 15: the maximum number of cycles one grant may be held before it is forcibly released (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 8 bits: request lines; bit i high means requester i wants the shared encoded resource.
REQ-005 SHALL have port done, input, 1 bit: the current grant holder releases the resource; only meaningful while gnt_valid=1.
REQ-006 SHALL have port gnt, output, 8 bits: one-hot grant; all zeros when no grant is active.
REQ-007 SHALL have port gnt_idx, output, 3 bits: binary index of the granted requester; 3'd0 when gnt_valid=0.
REQ-008 SHALL have port gnt_valid, output, 1 bit: high while a grant is active.
REQ-009 SHALL have port timeout, output, 1 bit: a one-cycle pulse when a grant is forcibly released at MAX_HOLD.

Function
REQ-010 SHALL implement two states: IDLE and GRANT.
REQ-011 SHALL keep a 3-bit round-robin pointer ptr that gives the highest-priority requester index.
REQ-012 SHALL, in IDLE, when req is nonzero, select the first set bit in order ptr, ptr+1, ..., ptr+7 (indices mod 8), then enter GRANT with gnt, gnt_idx and gnt_valid registered on the same edge.
  - Latency from req sampled high to gnt_valid high is 1 cycle.
REQ-013 SHALL stay in IDLE with all outputs zero while req=8'h00.
REQ-014 SHALL hold gnt and gnt_idx constant for the whole GRANT state, whatever other req bits do.
REQ-015 SHALL count hold cycles in GRANT with an 8-bit hold counter.
  - The counter is 0 in the first GRANT cycle and increments each cycle.
REQ-016 SHALL release the grant at the next edge when any of these holds in a GRANT cycle:
  - done=1;
  - req[gnt_idx]=0;
  - hold counter = MAX_HOLD-1.
REQ-017 SHALL, on release, set ptr to gnt_idx+1 (7 wraps to 0), clear gnt, gnt_idx and gnt_valid, and return to IDLE.
  - gnt_valid is therefore low for at least one cycle between two grants.
REQ-018 SHALL pulse timeout high for exactly the one cycle after a release caused only by the hold limit.
  - When done=1 or req[gnt_idx]=0 coincides with the limit, the release counts as normal and timeout stays 0.
REQ-019 SHALL ignore done while in IDLE.
REQ-020 SHALL guarantee that gnt has at most one bit set and that gnt equals 1<<gnt_idx whenever gnt_valid=1.
REQ-021 SHALL guarantee that every requester holding req high continuously is granted within 8 grants (starvation-free).

Reset
REQ-022 SHALL, while rst_n=0 and independent of clk:
  - clear gnt, gnt_idx, gnt_valid, timeout, the hold counter and ptr;
  - force the state to IDLE.
REQ-023 SHALL, on reset during GRANT, drop the grant immediately with no timeout pulse, and resume arbitration from ptr=0 after rst_n rises.

Verification
REQ-024 SHALL cover reset: after reset, req=8'h00 for 5 cycles -> gnt=8'h00, gnt_valid=0, gnt_idx=0 throughout.
REQ-025 SHALL cover the single requester: after reset, req=8'b00011100 -> one cycle later gnt=8'b00000100, gnt_idx=2. Then done=1 for one cycle -> next cycle gnt_valid=0, ptr=3. Next grant is gnt_idx=3.
REQ-026 SHALL cover rotation: req=8'hFF held, done pulsed in each grant -> grant order 0,1,2,...,7,0, with one idle cycle between grants.
REQ-027 SHALL cover timeout: MAX_HOLD=15, req=8'b00001000 held, done=0 -> gnt_idx=3 for exactly 15 cycles, then timeout=1 for one cycle with gnt_valid=0. Next grant gnt_idx=3 again, with ptr=4.
REQ-028 SHALL cover withdrawal plus wrap: with ptr=7, req=8'b10000001 -> gnt_idx=7. Then req[7] drops -> release, ptr=0, next gnt_idx=0.
REQ-029 SHALL cover mid-grant reset: assert rst_n=0 during gnt_idx=5 -> gnt=8'h00 with no clock edge and timeout=0. After release of reset with req=8'b00100001 -> gnt_idx=0.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with a bounded hold time.
// One grant at a time; a grant ends on done, on request withdrawal, or at MAX_HOLD.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;
    logic [2:0] sel;
    logic [2:0] cand;
    logic       found;
    logic       at_limit;
    logic       holder_req;
    logic       release_now;

    // First requester at or after ptr, scanning upward with wrap.
    always_comb begin
        sel   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cand = ptr + 3'(k);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // Release conditions for the current holder.
    always_comb begin
        at_limit    = (hold_cnt == HOLD_LAST);
        holder_req  = req[gnt_idx];
        release_now = done || !holder_req || at_limit;
    end

    // Arbitration state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= 8'd0;
            gnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state     <= GRANT;
                        gnt       <= 8'd1 << sel;
                        gnt_idx   <= sel;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= IDLE;
                        ptr       <= gnt_idx + 3'd1;
                        gnt       <= 8'd0;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= 8'd0;
                        // Only a pure hold-limit release is a timeout.
                        timeout   <= at_limit && !done && holder_req;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed bench for rr_arbiter_8.
// A cycle model predicts the outputs; directed steps pin literal values.
module tb_rr_arbiter_8;

    localparam int MH = 15;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_err    = 0;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .done(done),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the resource, for how long, and who is next.
    int m_valid;
    int m_idx;
    int m_ptr;
    int m_hold;
    int m_to;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0;
            m_idx   <= 0;
            m_ptr   <= 0;
            m_hold  <= 0;
            m_to    <= 0;
        end else if (m_valid == 0) begin
            m_to <= 0;
            if (req != 8'h00) begin
                m_valid <= 1;
                m_idx   <= pick(req, m_ptr);
                m_hold  <= 0;
            end
        end else begin
            m_to <= 0;
            if (done || !req[m_idx] || m_hold == MH - 1) begin
                m_valid <= 0;
                m_ptr   <= (m_idx + 1) % 8;
                m_to    <= (!done && req[m_idx]) ? 1 : 0;
            end else begin
                m_hold <= m_hold + 1;
            end
        end
    end

    // Compare on every falling edge once out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_valid", 32'(gnt_valid), 32'(m_valid));
            check("gnt", 32'(gnt), m_valid != 0 ? 32'(1) << m_idx : 32'd0);
            check("gnt_idx", 32'(gnt_idx), m_valid != 0 ? 32'(m_idx) : 32'd0);
            check("timeout", 32'(timeout), 32'(m_to));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_valid", 32'(gnt_valid), 32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_valid", 32'(gnt_valid), 32'h0);
            check("idle_idx", 32'(gnt_idx), 32'h0);
        end

        // Single requester group, done release, pointer advance.
        req = 8'b0001_1100;
        step();
        check("single_gnt", 32'(gnt), 32'h04);
        check("single_idx", 32'(gnt_idx), 32'd2);
        done = 1'b1;
        step();
        done = 1'b0;
        check("single_rel", 32'(gnt_valid), 32'h0);
        step();
        check("single_next", 32'(gnt_idx), 32'd3);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;
        step();

        // Full rotation from ptr=0.
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            check("rot_idx", 32'(gnt_idx), 32'(i % 8));
            check("rot_valid", 32'(gnt_valid), 32'h1);
            done = 1'b1;
            step();
            done = 1'b0;
            check("rot_gap", 32'(gnt_valid), 32'h0);
        end
        req = 8'h00;
        step();

        // Hold limit timeout.
        do_reset();
        req = 8'b0000_1000;
        step();
        for (int i = 0; i < 15; i++) begin
            check("hold_valid", 32'(gnt_valid), 32'h1);
            check("hold_idx", 32'(gnt_idx), 32'd3);
            step();
        end
        check("to_valid", 32'(gnt_valid), 32'h0);
        check("to_pulse", 32'(timeout), 32'h1);
        step();
        check("to_regrant", 32'(gnt_idx), 32'd3);
        check("to_cleared", 32'(timeout), 32'h0);
        req = 8'h00;
        step();
        check("wd_timeout", 32'(timeout), 32'h0);

        // done at the limit is a normal release.
        req = 8'b0000_1000;
        step();
        for (int i = 0; i < 14; i++) step();
        check("lim_valid", 32'(gnt_valid), 32'h1);
        done = 1'b1;
        step();
        done = 1'b0;
        check("lim_done_valid", 32'(gnt_valid), 32'h0);
        check("lim_done_to", 32'(timeout), 32'h0);
        req = 8'h00;
        step();

        // Withdrawal with pointer wrap.
        req = 8'b0100_0000;
        step();
        check("w6_idx", 32'(gnt_idx), 32'd6);
        req = 8'h00;
        step();
        req = 8'b1000_0001;
        step();
        check("w7_idx", 32'(gnt_idx), 32'd7);
        req = 8'b0000_0001;
        step();
        check("w7_rel", 32'(gnt_valid), 32'h0);
        step();
        check("wrap_idx", 32'(gnt_idx), 32'd0);
        check("wrap_gnt", 32'(gnt), 32'h01);
        req = 8'h00;
        step();

        // Mid-grant asynchronous reset.
        req = 8'b0010_0000;
        step();
        check("mr_idx", 32'(gnt_idx), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_gnt", 32'(gnt), 32'h0);
        check("mr_valid", 32'(gnt_valid), 32'h0);
        check("mr_timeout", 32'(timeout), 32'h0);
        check("mr_idx0", 32'(gnt_idx), 32'h0);
        req = 8'b0010_0001;
        step();
        rst_n = 1'b1;
        step();
        check("mr_resume", 32'(gnt_idx), 32'd0);
        check("mr_resume_v", 32'(gnt_valid), 32'h1);
        req = 8'h00;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
